// File: rtl/seg_pair_decoder.sv
// Two-digit seven-segment readback: settles the segment pair, decodes it to
// a byte and holds it in a single-entry valid/ready output register.
module seg_pair_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_hi,
  input  logic [6:0] seg_lo,
  input  logic       seg_valid,
  input  logic       out_ready,
  output logic [7:0] value_out,
  output logic       out_valid,
  output logic       bad_pattern,
  output logic       overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] SC = CW'(STABLE_CYCLES);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_e;

  // Bit 4 flags a legal hex glyph, bits 3:0 carry the digit.
  function automatic logic [4:0] dec7(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = 5'h10;
      7'b1111001: r = 5'h11;
      7'b0100100: r = 5'h12;
      7'b0110000: r = 5'h13;
      7'b0011001: r = 5'h14;
      7'b0010010: r = 5'h15;
      7'b0000010: r = 5'h16;
      7'b1111000: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0010000: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b0000011: r = 5'h1B;
      7'b1000110: r = 5'h1C;
      7'b0100001: r = 5'h1D;
      7'b0000110: r = 5'h1E;
      7'b0001110: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  ostate_e       state_q, state_d;
  logic [13:0]   cap_q, cap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [13:0]   last_q, last_d;
  logic          last_v_q, last_v_d;
  logic [7:0]    val_q, val_d;
  logic          bad_q, bad_d;
  logic          ovr_q, ovr_d;

  logic [13:0]   pair;
  logic [4:0]    dh, dl;
  logic          hit, report, load;

  // Settling counter, report detection and pattern decode.
  always_comb begin
    pair     = {seg_hi, seg_lo};
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    last_v_d = last_v_q;
    if (seg_valid) begin
      if (pair == cap_q) begin
        if (cnt_q != SC) cnt_d = cnt_q + CW'(1);
      end else begin
        cap_d = pair;
        cnt_d = CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
    // A saturated counter only re-fires when a fresh pair restarts it.
    hit    = seg_valid && (cnt_d == SC) &&
             ((pair != cap_q) || (cnt_q != SC));
    report = hit && (!last_v_q || (pair != last_q));
    dh     = dec7(seg_hi);
    dl     = dec7(seg_lo);
    load   = report && dh[4] && dl[4];
    bad_d  = report && !(dh[4] && dl[4]);
    if (report) begin
      last_d   = pair;
      last_v_d = 1'b1;
    end
  end

  // Output register next state, value and sticky overrun.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      EMPTY: begin
        if (load) state_d = FULL;
      end
      FULL: begin
        if (load) begin
          if (!out_ready) ovr_d = 1'b1;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (load) val_d = {dh[3:0], dl[3:0]};
  end

  // Output state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q    <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      last_v_q <= 1'b0;
      val_q    <= '0;
      bad_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      cap_q    <= cap_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      last_v_q <= last_v_d;
      val_q    <= val_d;
      bad_q    <= bad_d;
      ovr_q    <= ovr_d;
    end
  end

  assign value_out   = val_q;
  assign out_valid   = (state_q == FULL);
  assign bad_pattern = bad_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_seg_pair_decoder.sv
// Bench for seg_pair_decoder: default and single-sample builds share one
// stimulus stream and are each compared against a run-length reference.
module tb_seg_pair_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg_hi = '1;
  logic [6:0] seg_lo = '1;
  logic       seg_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic [7:0] vo0, vo1;
  logic       ov0, ov1, bp0, bp1, or0, or1;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always #5 clk = ~clk;

  seg_pair_decoder #(.STABLE_CYCLES(4)) u_dut0 (
    .clk(clk), .reset(reset), .seg_hi(seg_hi), .seg_lo(seg_lo),
    .seg_valid(seg_valid), .out_ready(out_ready), .value_out(vo0),
    .out_valid(ov0), .bad_pattern(bp0), .overrun(or0)
  );

  seg_pair_decoder #(.STABLE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .seg_hi(seg_hi), .seg_lo(seg_lo),
    .seg_valid(seg_valid), .out_ready(out_ready), .value_out(vo1),
    .out_valid(ov1), .bad_pattern(bp1), .overrun(or1)
  );

  // Reference state per build: length of the current run of identical
  // valid samples, the last reported pair and the output register.
  int         m_s     [2] = '{4, 1};
  int         m_run   [2];
  logic [13:0] m_rpair[2];
  logic [13:0] m_last [2];
  logic       m_lastv [2];
  logic [7:0] m_val   [2];
  logic       m_full  [2];
  logic       m_bad   [2];
  logic       m_ovr   [2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [13:0] pr(input logic [7:0] b);
    logic [3:0] h, l;
    h = b[7:4];
    l = b[3:0];
    return {HEX[h], HEX[l]};
  endfunction

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (HEX[i] == s) return i;
    return -1;
  endfunction

  task automatic model(input int k, input logic r, input logic v,
                       input logic [13:0] p, input logic rdy);
    int  h, l;
    logic rep;
    if (r) begin
      m_run[k] = 0; m_rpair[k] = '0; m_last[k] = '0; m_lastv[k] = 0;
      m_val[k] = '0; m_full[k] = 0; m_bad[k] = 0; m_ovr[k] = 0;
      return;
    end
    m_bad[k] = 0;
    if (v) begin
      m_run[k] = (m_run[k] > 0 && p == m_rpair[k]) ? m_run[k] + 1 : 1;
      m_rpair[k] = p;
    end else begin
      m_run[k] = 0;
    end
    rep = v && (m_run[k] == m_s[k]) && (!m_lastv[k] || p != m_last[k]);
    h = lookup(p[13:7]);
    l = lookup(p[6:0]);
    if (rep) begin
      m_last[k] = p;
      m_lastv[k] = 1;
    end
    if (rep && h >= 0 && l >= 0) begin
      if (m_full[k] && !rdy) m_ovr[k] = 1;
      m_val[k] = 8'(h * 16 + l);
      m_full[k] = 1;
    end else begin
      if (rep) m_bad[k] = 1;
      if (m_full[k] && rdy) m_full[k] = 0;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [13:0] p,
                      input logic rdy);
    reset = r;
    seg_valid = v;
    {seg_hi, seg_lo} = p;
    out_ready = rdy;
    @(posedge clk);
    model(0, r, v, p, rdy);
    model(1, r, v, p, rdy);
    #1;
    chk("val0", vo0, m_val[0]);
    chk("vld0", ov0, m_full[0]);
    chk("bad0", bp0, m_bad[0]);
    chk("ovr0", or0, m_ovr[0]);
    chk("val1", vo1, m_val[1]);
    chk("vld1", ov1, m_full[1]);
    chk("bad1", bp1, m_bad[1]);
    chk("ovr1", or1, m_ovr[1]);
  endtask

  task automatic hold(input logic [13:0] p, input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, p, rdy);
  endtask

  initial begin
    logic [13:0] p;
    int n;
    #2;
    step(1'b1, 1'b0, '1, 1'b0);
    step(1'b1, 1'b0, '1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '1, 1'b0);
    chk("idle_vld", ov0, 1'b0);

    hold(pr(8'hC5), 3, 1'b0);
    chk("c5_early", ov0, 1'b0);
    hold(pr(8'hC5), 1, 1'b0);
    chk("c5_vld", ov0, 1'b1);
    chk("c5_val", vo0, 8'hC5);
    hold(pr(8'hC5), 4, 1'b0);
    chk("c5_noev", ov0, 1'b1);
    step(1'b0, 1'b0, '1, 1'b1);
    chk("c5_pop", ov0, 1'b0);

    hold(pr(8'h12), 3, 1'b0);
    chk("x12_none", ov0, 1'b0);
    hold(pr(8'h13), 4, 1'b0);
    chk("x13_val", vo0, 8'h13);
    chk("x13_vld", ov0, 1'b1);
    step(1'b0, 1'b0, '1, 1'b1);

    hold({7'b1000000, 7'b1111111}, 4, 1'b0);
    chk("bad_hi", bp0, 1'b1);
    chk("bad_keep", vo0, 8'h13);
    step(1'b0, 1'b0, '1, 1'b0);
    chk("bad_pulse", bp0, 1'b0);

    step(1'b1, 1'b0, '1, 1'b0);
    hold(pr(8'h01), 4, 1'b0);
    hold(pr(8'h02), 4, 1'b0);
    chk("ovr_val", vo0, 8'h02);
    chk("ovr_set", or0, 1'b1);

    step(1'b1, 1'b0, '1, 1'b0);
    hold(pr(8'h01), 4, 1'b0);
    hold(pr(8'h02), 3, 1'b0);
    hold(pr(8'h02), 1, 1'b1);
    chk("rdy_vld", ov0, 1'b1);
    chk("rdy_val", vo0, 8'h02);
    chk("rdy_novr", or0, 1'b0);

    hold(pr(8'hAB), 2, 1'b0);
    step(1'b1, 1'b1, pr(8'hAB), 1'b0);
    chk("rst_vld", ov0, 1'b0);
    chk("rst_val", vo0, 8'h00);
    hold(pr(8'hAB), 4, 1'b0);
    chk("ab_val", vo0, 8'hAB);

    step(1'b1, 1'b0, '1, 1'b0);
    hold(pr(8'h7E), 1, 1'b0);
    chk("s1_vld", ov1, 1'b1);
    chk("s1_val", vo1, 8'h7E);

    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 9) == 0)
        p = {7'($urandom), 7'($urandom)};
      else
        p = pr(8'($urandom_range(0, 15) * 16 + $urandom_range(0, 3)));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        step($urandom_range(0, 60) == 0, $urandom_range(0, 7) != 0, p,
             $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
